// File: rtl/trng_postproc.sv
// trng_postproc: sample raw entropy, von Neumann correct, pack into bytes on valid/ready
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 block enable; low clears sampling/correction/packing state
//   raw_bit             asynchronous raw entropy bit
//   out_ready           consumer accepts the presented byte this cycle
//   out_data, out_valid corrected byte and its valid flag
//   health_fail         sticky stuck-source flag (repetition-count test)
// Build option: define TRNG_HEALTH_EN to include the repetition-count health test;
// without it health_fail is tied low.
module trng_postproc #(
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       raw_bit,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       health_fail
);
    localparam int DW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
    typedef enum logic {IDLE, PAIR} vn_state_e;
    logic          sync1_q, sync2_q;
    logic [DW-1:0] div_q, div_d;
    vn_state_e     state_q, state_d;
    logic          first_q, first_d;
    logic [7:0]    sh_q, sh_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          fail_q, fail_d;
    logic          tick, emit, load;
    assign tick = ena && (div_q == DW'(SAMPLE_DIV - 1));
    assign div_d = (!ena || tick) ? '0 : div_q + DW'(1);
    // The emitted bit is the first sample of a differing pair.
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        emit = 1'b0;
        if (!ena) begin
            state_d = IDLE;
            first_d = 1'b0;
        end else if (tick) begin
            if (state_q == IDLE) begin
                first_d = sync2_q;
                state_d = PAIR;
            end else begin
                emit = first_q != sync2_q;
                state_d = IDLE;
            end
        end
    end
    // A full packer waits for the output register; bits arriving meanwhile are dropped.
    assign load = ena && cnt_q == 4'd8 && (!valid_q || out_ready) && !fail_d;
    always_comb begin
        sh_d = sh_q;
        cnt_d = cnt_q;
        if (!ena) begin
            sh_d = '0;
            cnt_d = '0;
        end else if (load) begin
            cnt_d = '0;
        end else if (emit && cnt_q != 4'd8) begin
            sh_d = {sh_q[6:0], first_q};
            cnt_d = cnt_q + 4'd1;
        end
    end
    assign data_d = load ? sh_q : data_q;
    assign valid_d = fail_d ? 1'b0 : load ? 1'b1 : (valid_q && out_ready) ? 1'b0 : valid_q;
`ifdef TRNG_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT + 1);
    logic [RW-1:0] rc_q, rc_d;
    logic          last_q, last_d;
    // rc_q==0 means no previous sample, so the next one starts a fresh run.
    always_comb begin
        rc_d = rc_q;
        last_d = last_q;
        fail_d = fail_q;
        if (!ena) begin
            rc_d = '0;
        end else if (tick) begin
            last_d = sync2_q;
            rc_d = (rc_q != '0 && sync2_q == last_q) ?
                   (rc_q == RW'(REP_LIMIT) ? rc_q : rc_q + RW'(1)) : RW'(1);
            if (rc_d == RW'(REP_LIMIT)) fail_d = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_q <= '0;
            last_q <= 1'b0;
        end else begin
            rc_q <= rc_d;
            last_q <= last_d;
        end
    end
`else
    assign fail_d = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            div_q <= '0;
            state_q <= IDLE;
            first_q <= 1'b0;
            sh_q <= '0;
            cnt_q <= '0;
            data_q <= '0;
            valid_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            sync1_q <= raw_bit;
            sync2_q <= sync1_q;
            div_q <= div_d;
            state_q <= state_d;
            first_q <= first_d;
            sh_q <= sh_d;
            cnt_q <= cnt_d;
            data_q <= data_d;
            valid_q <= valid_d;
            fail_q <= fail_d;
        end
    end
    assign out_data = data_q;
    assign out_valid = valid_q;
    assign health_fail = fail_q;
endmodule

// File: tb/tb_trng_postproc.sv
// tb_trng_postproc: directed bench for trng_postproc with SAMPLE_DIV=1, REP_LIMIT=32
module tb_trng_postproc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic raw_bit = 1'b0;
    logic out_ready = 1'b1;
    logic [7:0] out_data;
    logic out_valid;
    logic health_fail;
    int checks = 0;
    int failures = 0;
    int pend = 0;
    int vcycles = 0;
    logic [7:0] got[$];

    trng_postproc #(.SAMPLE_DIV(1), .REP_LIMIT(32)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .raw_bit(raw_bit),
        .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    // Record every handshake; values are stable from negedge+1 to the next posedge.
    always @(negedge clk) begin
        #1;
        if (out_valid) vcycles++;
        if (out_valid && out_ready) got.push_back(out_data);
    end

    function automatic logic [7:0] gq(input int i);
        return i < got.size() ? got[i] : 8'hxx;
    endfunction

    // Raw bit k is sampled two clocks after it is driven, so ena rises with the
    // third bit to make the first driven bit the first sample of a pair.
    task automatic push_bit(input logic b);
        @(negedge clk);
        raw_bit = b;
        if (pend > 0) begin
            pend--;
            if (pend == 0) ena = 1'b1;
        end
    endtask

    task automatic push_pairs(input logic a, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            push_bit(a);
            push_bit(b);
        end
    endtask

    task automatic restart;
        @(negedge clk);
        ena = 1'b0;
        raw_bit = 1'b0;
        repeat (2) @(negedge clk);
        pend = 3;
    endtask

    task automatic flush;
        repeat (6) push_bit(1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        #2;
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (health_fail !== 1'b0) begin failures++; $display("FAIL reset_health got=%b exp=0", health_fail); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ones;
        restart; got.delete(); vcycles = 0;
        push_pairs(1'b1, 1'b0, 8);
        flush;
        checks++; if (got.size() != 1) begin failures++; $display("FAIL ones_count got=%0d exp=1", got.size()); end
        checks++; if (gq(0) !== 8'hFF) begin failures++; $display("FAIL ones_data got=%h exp=ff", gq(0)); end
        checks++; if (vcycles != 1) begin failures++; $display("FAIL ones_pulse got=%0d exp=1", vcycles); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ones_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_patterns;
        restart; got.delete();
        for (int i = 0; i < 4; i++) begin
            push_pairs(1'b1, 1'b0, 1);
            push_pairs(1'b0, 1'b1, 1);
        end
        push_pairs(1'b0, 1'b1, 8);
        flush;
        checks++; if (got.size() != 2) begin failures++; $display("FAIL pat_count got=%0d exp=2", got.size()); end
        checks++; if (gq(0) !== 8'hAA) begin failures++; $display("FAIL pat_aa got=%h exp=aa", gq(0)); end
        checks++; if (gq(1) !== 8'h00) begin failures++; $display("FAIL pat_00 got=%h exp=00", gq(1)); end
    endtask

    task automatic test_discard_pairs;
        restart; got.delete(); vcycles = 0;
        for (int i = 0; i < 50; i++) begin
            push_pairs(1'b0, 1'b0, 1);
            push_pairs(1'b1, 1'b1, 1);
        end
        checks++; if (got.size() != 0) begin failures++; $display("FAIL same_count got=%0d exp=0", got.size()); end
        checks++; if (vcycles != 0) begin failures++; $display("FAIL same_valid got=%0d exp=0", vcycles); end
        push_pairs(1'b1, 1'b0, 8);
        flush;
        checks++; if (got.size() != 1) begin failures++; $display("FAIL same_after_count got=%0d exp=1", got.size()); end
        checks++; if (gq(0) !== 8'hFF) begin failures++; $display("FAIL same_after_data got=%h exp=ff", gq(0)); end
    endtask

    task automatic test_back_pressure;
        out_ready = 1'b0;
        restart; got.delete();
        push_pairs(1'b1, 1'b0, 16);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_mid_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'hFF) begin failures++; $display("FAIL bp_mid_data got=%h exp=ff", out_data); end
        push_pairs(1'b1, 1'b0, 8);
        flush;
        checks++; if (got.size() != 0) begin failures++; $display("FAIL bp_held_count got=%0d exp=0", got.size()); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_held_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'hFF) begin failures++; $display("FAIL bp_held_data got=%h exp=ff", out_data); end
        @(negedge clk);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (got.size() != 2) begin failures++; $display("FAIL bp_drain_count got=%0d exp=2", got.size()); end
        checks++; if (gq(0) !== 8'hFF) begin failures++; $display("FAIL bp_drain_b0 got=%h exp=ff", gq(0)); end
        checks++; if (gq(1) !== 8'hFF) begin failures++; $display("FAIL bp_drain_b1 got=%h exp=ff", gq(1)); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_health;
        logic exp_hf;
        logic exp_v;
`ifdef TRNG_HEALTH_EN
        exp_hf = 1'b1; exp_v = 1'b0;
`else
        exp_hf = 1'b0; exp_v = 1'b1;
`endif
        out_ready = 1'b0;
        restart; got.delete();
        push_pairs(1'b1, 1'b0, 8);
        flush;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hf_pending got=%b exp=1", out_valid); end
        repeat (20) push_bit(1'b1);
        checks++; if (health_fail !== 1'b0) begin failures++; $display("FAIL hf_early got=%b exp=0", health_fail); end
        repeat (40) push_bit(1'b1);
        checks++; if (health_fail !== exp_hf) begin failures++; $display("FAIL hf_trip got=%b exp=%b", health_fail, exp_hf); end
        checks++; if (out_valid !== exp_v) begin failures++; $display("FAIL hf_valid got=%b exp=%b", out_valid, exp_v); end
        @(negedge clk);
        out_ready = 1'b1;
        restart;
        repeat (4) @(negedge clk);
        checks++; if (health_fail !== exp_hf) begin failures++; $display("FAIL hf_sticky got=%b exp=%b", health_fail, exp_hf); end
        checks++; if (got.size() != (exp_v ? 1 : 0)) begin failures++; $display("FAIL hf_drain got=%0d exp=%0d", got.size(), exp_v ? 1 : 0); end
    endtask

    task automatic test_reset_and_ena;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b0;
        restart; got.delete();
        push_pairs(1'b1, 1'b0, 8);
        push_pairs(1'b0, 1'b1, 5);
        flush;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'hFF) begin failures++; $display("FAIL rst_pre_data got=%h exp=ff", out_data); end
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rst_async_data got=%h exp=00", out_data); end
        checks++; if (health_fail !== 1'b0) begin failures++; $display("FAIL rst_async_health got=%b exp=0", health_fail); end
        @(negedge clk);
        rst_n = 1'b1;
        raw_bit = 1'b1;
        out_ready = 1'b1;
        got.delete();
        push_bit(1'b0);
        push_pairs(1'b1, 1'b0, 7);
        flush;
        checks++; if (got.size() != 1) begin failures++; $display("FAIL rst_post_count got=%0d exp=1", got.size()); end
        checks++; if (gq(0) !== 8'hFF) begin failures++; $display("FAIL rst_post_data got=%h exp=ff", gq(0)); end
        restart; got.delete();
        push_pairs(1'b0, 1'b1, 4);
        restart;
        push_pairs(1'b1, 1'b0, 8);
        flush;
        checks++; if (got.size() != 1) begin failures++; $display("FAIL ena_count got=%0d exp=1", got.size()); end
        checks++; if (gq(0) !== 8'hFF) begin failures++; $display("FAIL ena_data got=%h exp=ff", gq(0)); end
    endtask

    initial begin
        test_reset;
        test_ones;
        test_patterns;
        test_discard_pairs;
        test_back_pressure;
        test_health;
        test_reset_and_ena;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
